// File: rtl/prim_timer_ctrl.sv
// prim_timer_ctrl: one-shot/periodic timer controller driving an external down counter
// Ports: i_clk, i_rstn (synchronous, active-low); i_start/i_stop/i_periodic/i_period/i_presc
//   request and configure a run; i_irq_clr clears o_irq; i_count is the counter feedback;
//   o_cnt_load/o_cnt_load_data/o_cnt_en drive the counter; o_busy, o_expire, o_irq report status.
// Define PRIM_TIMER_PRESCALER_EN to build the tick prescaler; otherwise every RUN cycle ticks.
module prim_timer_ctrl #(
   parameter int WIDTH       = 32,
   parameter int PRESC_WIDTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_start,
   input  logic                   i_stop,
   input  logic                   i_periodic,
   input  logic [WIDTH-1:0]       i_period,
   input  logic [PRESC_WIDTH-1:0] i_presc,
   input  logic                   i_irq_clr,
   input  logic [WIDTH-1:0]       i_count,
   output logic                   o_cnt_load,
   output logic [WIDTH-1:0]       o_cnt_load_data,
   output logic                   o_cnt_en,
   output logic                   o_busy,
   output logic                   o_expire,
   output logic                   o_irq
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t state, state_nxt;
   logic periodic_q;
   logic start_ok, latch, term, expire_set, reload, tick;
   assign start_ok = i_start && (i_period != '0);
   assign latch = start_ok && !i_stop;
   assign term = (state == RUN) && (i_count == '0);
   // a stop or a restart abandons the run, so a coincident terminal cycle does not expire
   assign expire_set = term && !i_stop && !start_ok;
   assign reload = expire_set && periodic_q;
`ifdef PRIM_TIMER_PRESCALER_EN
   logic [PRESC_WIDTH-1:0] presc_q, pcnt;
   assign tick = pcnt == presc_q;
   // held at zero outside RUN so LOAD always starts a fresh prescale interval
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         presc_q <= '0;
         pcnt <= '0;
      end else begin
         if (latch) presc_q <= i_presc;
         pcnt <= (state != RUN || reload || tick) ? '0 : pcnt + 1'b1;
      end
   end
`else
   logic unused_presc;
   assign unused_presc = ^i_presc;
   assign tick = 1'b1;
`endif
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state <= IDLE;
         periodic_q <= 1'b0;
         o_cnt_load_data <= '0;
         o_expire <= 1'b0;
         o_irq <= 1'b0;
      end else begin
         state <= state_nxt;
         if (latch) begin
            periodic_q <= i_periodic;
            o_cnt_load_data <= i_period;
         end
         o_expire <= expire_set;
         // setting wins over clearing in both the terminal cycle and the pulse cycle
         o_irq <= expire_set || o_expire || (o_irq && !i_irq_clr);
      end
   end
   always_comb begin
      state_nxt = state;
      state_nxt = i_stop ? IDLE :
                  start_ok ? LOAD :
                  (state == LOAD) ? RUN :
                  (expire_set && !periodic_q) ? IDLE : state;
   end
   assign o_cnt_load = ((state == LOAD) && !i_stop) || reload;
   assign o_cnt_en = (state == RUN) && tick && (i_count != '0) && !o_cnt_load && !i_stop;
   assign o_busy = state != IDLE;
endmodule

// File: tb/tb_prim_timer_ctrl.sv
// tb_prim_timer_ctrl: randomized and directed checks of prim_timer_ctrl against a schedule-based model
module tb_prim_timer_ctrl;
   localparam int W = 32;
   localparam int PW = 8;
`ifdef PRIM_TIMER_PRESCALER_EN
   localparam bit PRESC = 1'b1;
`else
   localparam bit PRESC = 1'b0;
`endif
   logic clk = 1'b0;
   logic rstn = 1'b1, start = 1'b0, stop = 1'b0, periodic = 1'b0, irq_clr = 1'b0;
   logic [W-1:0] period = '0;
   logic [PW-1:0] presc = '0;
   logic [W-1:0] cnt;
   logic o_cnt_load, o_cnt_en, o_busy, o_expire, o_irq;
   logic [W-1:0] o_cnt_load_data;
   int checks = 0, errors = 0, cyc = 0;
   bit m_act = 0, m_per = 0, m_exp = 0, m_irq = 0;
   int m_load = 0, m_term = 0, m_p = 0, m_d = 0;
   logic [W-1:0] m_ld = '0;

   prim_timer_ctrl #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_stop(stop), .i_periodic(periodic),
      .i_period(period), .i_presc(presc), .i_irq_clr(irq_clr), .i_count(cnt),
      .o_cnt_load(o_cnt_load), .o_cnt_load_data(o_cnt_load_data), .o_cnt_en(o_cnt_en),
      .o_busy(o_busy), .o_expire(o_expire), .o_irq(o_irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rstn) cnt <= '0;
      else if (o_cnt_load) cnt <= o_cnt_load_data;
      else if (o_cnt_en) cnt <= cnt - 1'b1;
   end

   // Model: a run started in cycle n loads in n+1 and hits terminal count in n+2+P*(D+1);
   // periodic runs hit terminal again every P*(D+1)+1 cycles; expire follows terminal by one cycle.
   task automatic step();
      bit term, e;
      @(posedge clk);
      term = m_act && cyc == m_term;
      e = 1'b0;
      if (!rstn) begin
         m_act = 0; m_exp = 0; m_irq = 0; m_ld = '0;
      end else begin
         if (stop) m_act = 0;
         else if (start && period != '0) begin
            m_act = 1; m_per = periodic; m_p = int'(period); m_d = PRESC ? int'(presc) : 0;
            m_ld = period; m_load = cyc + 1; m_term = cyc + 2 + m_p * (m_d + 1);
         end else if (term) begin
            e = 1'b1;
            if (m_per) m_term = cyc + 1 + m_p * (m_d + 1);
            else m_act = 0;
         end
         m_irq = e || m_exp || (m_irq && !irq_clr);
         m_exp = e;
      end
      cyc++;
      #1;
      start = 0; stop = 0; irq_clr = 0; rstn = 1;
   endtask

   task automatic test_reset();
      rstn = 0;
      step();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      checks++; if (o_expire !== 1'b0) begin errors++; $display("FAIL reset_expire: got %b want 0", o_expire); end
      checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", o_irq); end
      checks++; if (o_cnt_load !== 1'b0 || o_cnt_en !== 1'b0) begin errors++; $display("FAIL reset_cnt_ctrl: load=%b en=%b want 0/0", o_cnt_load, o_cnt_en); end
      checks++; if (o_cnt_load_data !== '0) begin errors++; $display("FAIL reset_load_data: got %0d want 0", o_cnt_load_data); end
      step();
   endtask

   task automatic test_oneshot();
      start = 1; period = 3; periodic = 0; presc = 0;
      step();
      checks++; if (o_cnt_load !== 1'b1 || o_cnt_load_data !== 3) begin errors++; $display("FAIL oneshot_load: load=%b data=%0d want 1/3", o_cnt_load, o_cnt_load_data); end
      for (int k = 2; k <= 5; k++) begin
         step();
         checks++; if (cnt !== W'(5 - k) || o_busy !== 1'b1 || o_expire !== 1'b0) begin errors++; $display("FAIL oneshot_count c%0d: cnt=%0d busy=%b exp=%b want %0d/1/0", k, cnt, o_busy, o_expire, 5 - k); end
      end
      step();
      checks++; if (o_expire !== 1'b1 || o_irq !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL oneshot_expire: exp=%b irq=%b busy=%b want 1/1/0", o_expire, o_irq, o_busy); end
      step();
      checks++; if (o_expire !== 1'b0) begin errors++; $display("FAIL oneshot_pulse_width: exp=%b want 0", o_expire); end
   endtask

   task automatic test_periodic_irq();
      bit want;
      start = 1; period = 2; periodic = 1; presc = 0;
      step();
      for (int k = 1; k <= 12; k++) begin
         want = (k >= 5 && (k - 5) % 3 == 0);
         checks++; if (o_expire !== want) begin errors++; $display("FAIL periodic_expire c%0d: got %b want %b", k, o_expire, want); end
         if (k < 12) step();
      end
      irq_clr = 1;
      step();
      checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", o_irq); end
      step();
      checks++; if (o_expire !== 1'b1 || o_irq !== 1'b1) begin errors++; $display("FAIL periodic_reexpire: exp=%b irq=%b want 1/1", o_expire, o_irq); end
      irq_clr = 1;
      step();
      checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL irq_set_beats_clear: got %b want 1", o_irq); end
      stop = 1;
      step();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL periodic_stop: busy=%b want 0", o_busy); end
   endtask

   task automatic test_prescaler();
      int iv, dd, c0, e0, e1, n0, n1;
      iv = PRESC ? 9 : 3; dd = PRESC ? 3 : 0;
      e0 = -1; e1 = -1; n0 = -1; n1 = -1;
      start = 1; period = 2; periodic = 1; presc = 3; c0 = cyc;
      step();
      for (int k = 0; k < 40; k++) begin
         if (o_cnt_en && n0 < 0) n0 = cyc;
         else if (o_cnt_en && n1 < 0) n1 = cyc;
         if (o_expire && e0 < 0) e0 = cyc;
         else if (o_expire && e1 < 0) e1 = cyc;
         step();
      end
      checks++; if (n0 != c0 + 2 + dd) begin errors++; $display("FAIL presc_first_en: cycle %0d want %0d", n0 - c0, 2 + dd); end
      checks++; if (n1 - n0 != dd + 1) begin errors++; $display("FAIL presc_en_gap: %0d want %0d", n1 - n0, dd + 1); end
      checks++; if (e0 != c0 + 3 + 2 * (dd + 1)) begin errors++; $display("FAIL presc_first_expire: cycle %0d want %0d", e0 - c0, 3 + 2 * (dd + 1)); end
      checks++; if (e1 - e0 != iv) begin errors++; $display("FAIL presc_interval: %0d want %0d", e1 - e0, iv); end
      stop = 1;
      step();
   endtask

   task automatic test_stop();
      bit found;
      found = 0;
      irq_clr = 1;
      step();
      start = 1; period = 5; periodic = 0; presc = 0;
      step();
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         found = (o_busy && cnt == 1);
      end
      checks++; if (!found) begin errors++; $display("FAIL stop_wait: count 1 not reached, cnt=%0d", cnt); end
      stop = 1;
      #1;
      checks++; if (o_cnt_en !== 1'b0 || o_cnt_load !== 1'b0) begin errors++; $display("FAIL stop_mask: en=%b load=%b want 0/0", o_cnt_en, o_cnt_load); end
      step();
      checks++; if (o_busy !== 1'b0 || o_expire !== 1'b0) begin errors++; $display("FAIL stop_idle: busy=%b exp=%b want 0/0", o_busy, o_expire); end
      for (int k = 0; k < 6; k++) begin
         step();
         checks++; if (o_expire !== 1'b0 || o_irq !== 1'b0 || o_cnt_en !== 1'b0) begin errors++; $display("FAIL stop_quiet: exp=%b irq=%b en=%b want 0/0/0", o_expire, o_irq, o_cnt_en); end
      end
      start = 1; stop = 1; period = 4;
      step();
      checks++; if (o_busy !== 1'b0 || o_cnt_load !== 1'b0) begin errors++; $display("FAIL start_stop_idle: busy=%b load=%b want 0/0", o_busy, o_cnt_load); end
   endtask

   task automatic test_zero_period();
      start = 1; period = 0; periodic = 0;
      step();
      checks++; if (o_busy !== 1'b0 || o_cnt_load !== 1'b0) begin errors++; $display("FAIL zero_reject: busy=%b load=%b want 0/0", o_busy, o_cnt_load); end
      for (int k = 0; k < 6; k++) begin
         step();
         checks++; if (o_expire !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL zero_quiet: exp=%b busy=%b want 0/0", o_expire, o_busy); end
      end
   endtask

   task automatic test_restart();
      int r, ecyc;
      bit found;
      found = 0; ecyc = -1;
      start = 1; period = 6; periodic = 0;
      step();
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         found = (o_busy && cnt == 3);
      end
      checks++; if (!found) begin errors++; $display("FAIL restart_wait: count 3 not reached, cnt=%0d", cnt); end
      start = 1; period = 5; r = cyc;
      step();
      checks++; if (o_cnt_load !== 1'b1 || o_cnt_load_data !== 5) begin errors++; $display("FAIL restart_load: load=%b data=%0d want 1/5", o_cnt_load, o_cnt_load_data); end
      step();
      checks++; if (cnt !== 5) begin errors++; $display("FAIL restart_count: cnt=%0d want 5", cnt); end
      for (int k = 0; k < 20 && ecyc < 0; k++) begin
         if (o_expire) ecyc = cyc;
         else step();
      end
      checks++; if (ecyc != r + 8) begin errors++; $display("FAIL restart_expire: cycle %0d want %0d", ecyc - r, 8); end
   endtask

   task automatic test_reset_midrun();
      int c0, ecyc;
      ecyc = -1;
      start = 1; period = 4; periodic = 1;
      step();
      for (int k = 0; k < 4; k++) step();
      rstn = 0;
      step();
      checks++; if (o_busy !== 1'b0 || o_expire !== 1'b0 || o_irq !== 1'b0) begin errors++; $display("FAIL midrun_reset_status: busy=%b exp=%b irq=%b want 0/0/0", o_busy, o_expire, o_irq); end
      checks++; if (o_cnt_load !== 1'b0 || o_cnt_en !== 1'b0 || o_cnt_load_data !== '0) begin errors++; $display("FAIL midrun_reset_cnt: load=%b en=%b data=%0d want 0/0/0", o_cnt_load, o_cnt_en, o_cnt_load_data); end
      start = 1; period = 2; periodic = 0; c0 = cyc;
      step();
      for (int k = 0; k < 20 && ecyc < 0; k++) begin
         if (o_expire) ecyc = cyc;
         else step();
      end
      checks++; if (ecyc != c0 + 5) begin errors++; $display("FAIL midrun_restart_expire: cycle %0d want 5", ecyc - c0); end
   endtask

   task automatic test_random();
      int s;
      bit ld, en;
      for (int i = 0; i < 3000; i++) begin
         s = m_term - m_p * (m_d + 1);
         ld = m_act && (cyc == m_load || (cyc == m_term && m_per));
         en = m_act && cyc >= s && cyc < m_term && ((cyc - s) % (m_d + 1) == m_d);
         checks++; if (o_expire !== m_exp) begin errors++; $display("FAIL rand_expire c%0d: got %b want %b", cyc, o_expire, m_exp); end
         checks++; if (o_busy !== m_act) begin errors++; $display("FAIL rand_busy c%0d: got %b want %b", cyc, o_busy, m_act); end
         checks++; if (o_irq !== m_irq) begin errors++; $display("FAIL rand_irq c%0d: got %b want %b", cyc, o_irq, m_irq); end
         checks++; if (o_cnt_load !== ld) begin errors++; $display("FAIL rand_load c%0d: got %b want %b", cyc, o_cnt_load, ld); end
         checks++; if (o_cnt_en !== en) begin errors++; $display("FAIL rand_en c%0d: got %b want %b", cyc, o_cnt_en, en); end
         checks++; if (o_cnt_load_data !== m_ld) begin errors++; $display("FAIL rand_load_data c%0d: got %0d want %0d", cyc, o_cnt_load_data, m_ld); end
         if ($urandom_range(0, 99) < 4) begin
            start = 1;
            period = m_act ? W'($urandom_range(1, 6)) : W'($urandom_range(0, 6));
            periodic = 1'($urandom_range(0, 1));
            presc = PW'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 59) == 0) stop = 1;
         if ($urandom_range(0, 7) == 0) irq_clr = 1;
         if ($urandom_range(0, 299) == 0) rstn = 0;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic_irq();
      test_prescaler();
      test_stop();
      test_zero_period();
      test_restart();
      test_reset_midrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/prim_timer_ctrl.md
# prim_timer_ctrl

Programmable one-shot/periodic timer controller that sits directly upstream of the primitive down counter. It drives the counter's load, load-data and enable inputs and monitors its count output. It generates an expiry pulse and a sticky interrupt flag. An optional prescaler can slow the decrement rate.

## Interface
- `WIDTH`, 32: counter/period width; must match the attached down counter.
- `PRESC_WIDTH`, 8: prescaler divide-value width.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_rstn` in 1: reset, synchronous, active-low.
- `i_start` in 1: start/restart request, sampled each cycle.
- `i_stop` in 1: abort request.
- `i_periodic` in 1: 1 = auto-reload mode, 0 = one-shot; latched on start.
- `i_period` in WIDTH: terminal period P; latched on start.
- `i_presc` in PRESC_WIDTH: divide value D (tick every D+1 cycles); latched on start.
- `i_irq_clr` in 1: clears `o_irq`.
- `i_count` in WIDTH: counter `o_count` feedback.
- `o_cnt_load` out 1: counter synchronous load.
- `o_cnt_load_data` out WIDTH: latched period, registered.
- `o_cnt_en` out 1: counter decrement enable.
- `o_busy` out 1: high in LOAD or RUN.
- `o_expire` out 1: one-cycle expiry pulse, registered.
- `o_irq` out 1: sticky expiry flag.

## Operation
- FSM states: IDLE, LOAD, RUN.
- **IDLE**
  - `i_start` with `i_period != 0` latches period, mode and prescale, then goes to LOAD.
  - `i_start` with `i_period == 0` is rejected: stay IDLE, no expire.
- **LOAD**
  - `o_cnt_load = 1`, `o_cnt_load_data` = latched P.
  - Prescaler count cleared.
  - Next state RUN.
- **RUN**
  - Tick: prescaler count equals latched D. The prescaler count increments in RUN and wraps to 0 on tick.
  - `o_cnt_en = RUN & tick & (i_count != 0)`.
- **Terminal: RUN with `i_count == 0`**
  - Registers `o_expire = 1` and sets `o_irq` for the next cycle.
  - One-shot: next state IDLE.
  - Periodic: `o_cnt_load = 1` in the same cycle (combinational), prescaler cleared, stay RUN.
- **Priority and boundary rules**
  - `i_stop` beats `i_start`. `i_stop` in LOAD/RUN forces IDLE with no expire; `o_cnt_en` and `o_cnt_load` are 0 from that cycle.
  - `i_start` in LOAD/RUN restarts: re-latch inputs, go to LOAD, no expire for the aborted run. Restart also beats a coincident terminal condition.
  - Set beats clear: if expire and `i_irq_clr` coincide, `o_irq` stays 1.
  - `o_cnt_load` and `o_cnt_en` are never both 1. Load takes precedence; `o_cnt_en` is masked when `o_cnt_load` is 1.
- **Arithmetic**
  - Prescaler is PRESC_WIDTH bits. D = max value gives 2^PRESC_WIDTH cycles per tick.
  - No wrap handling on the counter: the block never enables the counter at 0.

## Timing
- **Reset** (any edge with `i_rstn = 0`): state IDLE, `o_busy = 0`, `o_expire = 0`, `o_irq = 0`, `o_cnt_load = 0`, `o_cnt_en = 0`, `o_cnt_load_data = 0`, prescaler 0, latched mode 0. Mid-run reset abandons the run with no expire.
- **No prescaler, start sampled in cycle 0:**
  - Cycle 1: LOAD.
  - Count P visible in cycle 2.
  - Count reaches 0 in cycle P+2.
  - `o_expire` high in cycle P+3.
- **One-shot:** `o_busy` high in cycles 1..P+2, low from cycle P+3.
- **Periodic, interval P+1 cycles:** terminal cycles P+2, 2P+3, …; `o_expire` one cycle after each.
- **With prescaler D:** each decrement takes D+1 cycles, so interval = P·(D+1)+1 cycles. The terminal cycle is not prescaled.

## Configuration
- `PRIM_TIMER_PRESCALER_EN` defined: prescaler implemented as described.
- Undefined: no prescaler register. tick = 1 every RUN cycle, `i_presc` is ignored, and timing equals the D = 0 case.

## Test plan
- Reset, then one-shot P=3, D=0, start in cycle 0: load in cycle 1, counts 3,2,1,0 in cycles 2–5, `o_expire` pulse in cycle 6, `o_irq` = 1, `o_busy` = 0 from cycle 6.
- Periodic P=2, D=0: `o_expire` pulses every 3 cycles. `i_irq_clr` on a non-expire cycle drops `o_irq`; clear coincident with expire leaves `o_irq` = 1.
- Prescaler P=2, D=3 (macro on): `o_cnt_en` high every 4th RUN cycle, expire interval 9 cycles. Same stimulus with macro off: interval 3.
- `i_stop` with count = 1: no `o_expire`, `o_busy` = 0 next cycle, `o_cnt_en` = 0. Simultaneous `i_start` + `i_stop` in IDLE: stays IDLE.
- `i_start` with P=0: no load, no expire, `o_busy` = 0. Restart mid-run with P=5: reload to 5, no expire for the aborted run.
- `i_rstn` = 0 in RUN for 1 cycle: all outputs at reset values next cycle, no expire; normal start works afterwards.
